// File: rtl/neuron_pkg.sv
// +--------------------------------------------------------------------------+
// | neuron_pkg : shared state encoding and default sizing for neuron_body    |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package neuron_pkg;

  localparam int WINDOW_DEF = 16;
  localparam int ACC_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INTEGRATE = 2'd1,
    DONE      = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/popcount.sv
// +--------------------------------------------------------------------------+
// | popcount : combinational count of set bits in a vector                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module popcount
  import neuron_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_bits,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(in_bits[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/neuron_body.sv
// +--------------------------------------------------------------------------+
// | neuron_body : windowed integrate-and-fire neuron, one spike per window.  |
// |               Optional leak when NEURON_BODY_LEAK_EN is defined.         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module neuron_body
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int WINDOW   = WINDOW_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_rdy,
  input  logic [N_INPUTS-1:0] prod_in,
  input  logic [ACC_W-1:0]    threshold,
  output logic                out,
  output logic [3:0]          out_time,
  output logic                fired,
  output logic                done
);

  localparam int           CNT_W    = $clog2(N_INPUTS + 1);
  localparam logic [3:0]   LAST_CYC = 4'(WINDOW - 1);
  localparam logic [ACC_W:0] ACC_MAX = {1'b0, {ACC_W{1'b1}}};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       cyc_q, cyc_d;
  logic [ACC_W-1:0] thr_q, thr_d;
  logic             out_q, out_d;
  logic             fired_q, fired_d;
  logic [3:0]       out_time_q, out_time_d;

  logic [CNT_W-1:0] pop_cnt;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_upd;

  popcount #(
    .WIDTH (N_INPUTS),
    .CNT_W (CNT_W)
  ) u_popcount (
    .in_bits (prod_in),
    .count   (pop_cnt)
  );

  // One extra bit of headroom lets the saturation test see the carry.
  always_comb begin
    acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(pop_cnt);
    acc_upd = (acc_sum > ACC_MAX) ? ACC_MAX[ACC_W-1:0] : acc_sum[ACC_W-1:0];
`ifdef NEURON_BODY_LEAK_EN
    if (pop_cnt == '0) begin
      acc_upd = (acc_q == '0) ? '0 : acc_q - ACC_W'(1);
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cyc_d      = cyc_q;
    thr_d      = thr_q;
    out_d      = 1'b0;
    fired_d    = fired_q;
    out_time_d = out_time_q;
    case (state_q)
      IDLE: begin
        if (in_rdy) begin
          state_d    = INTEGRATE;
          acc_d      = '0;
          cyc_d      = '0;
          thr_d      = threshold;
          fired_d    = 1'b0;
          out_time_d = LAST_CYC;
        end
      end
      INTEGRATE: begin
        acc_d = acc_upd;
        // fired_q doubles as the once-per-window lockout.
        if (!fired_q && (acc_upd >= thr_q)) begin
          out_d      = 1'b1;
          fired_d    = 1'b1;
          out_time_d = cyc_q;
        end
        if (cyc_q == LAST_CYC) begin
          state_d = DONE;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cyc_q      <= '0;
      thr_q      <= '0;
      out_q      <= 1'b0;
      fired_q    <= 1'b0;
      out_time_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cyc_q      <= cyc_d;
      thr_q      <= thr_d;
      out_q      <= out_d;
      fired_q    <= fired_d;
      out_time_q <= out_time_d;
    end
  end

  assign out      = out_q;
  assign fired    = fired_q;
  assign out_time = out_time_q;
  assign done     = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_neuron_body.sv
// +--------------------------------------------------------------------------+
// | tb_neuron_body : scoreboard bench driving an 8-bit and a 4-bit neuron    |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_neuron_body;

  typedef logic [3:0] pat_t [16];
  typedef struct {
    int k;
    int fired;
    int out_time;
    int pulses;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_rdy = 1'b0;
  logic [3:0] prod_in = '0;
  logic [7:0] threshold = '0;

  logic       out8, fired8, done8;
  logic [3:0] ot8;
  logic       out4, fired4, done4;
  logic [3:0] ot4;

  neuron_body #(.N_INPUTS(4), .WINDOW(16), .ACC_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_rdy(in_rdy), .prod_in(prod_in),
    .threshold(threshold), .out(out8), .out_time(ot8), .fired(fired8), .done(done8)
  );

  neuron_body #(.N_INPUTS(4), .WINDOW(16), .ACC_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_rdy(in_rdy), .prod_in(prod_in),
    .threshold(threshold[3:0]), .out(out4), .out_time(ot4), .fired(fired4), .done(done4)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int   n_checks = 0;
  int   n_pass = 0;
  int   win_start = 0;
  exp_t q8[$];
  exp_t q4[$];
  int   pulses[2];
  int   first_k[2];

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  function automatic exp_t model(input int thr, input pat_t pat, input int accw);
    exp_t e;
    int   acc = 0;
    int   lim = (1 << accw) - 1;
    int   p;
    e.k = -1;
    for (int k = 0; k < 16; k++) begin
      p = 0;
      for (int b = 0; b < 4; b++) if (pat[k][b]) p++;
`ifdef NEURON_BODY_LEAK_EN
      if (p == 0 && acc > 0) acc = acc - 1;
`endif
      acc = acc + p;
      if (acc > lim) acc = lim;
      if (e.k < 0 && acc >= thr) e.k = k;
    end
    e.fired    = (e.k >= 0) ? 1 : 0;
    e.out_time = (e.k >= 0) ? e.k : 15;
    e.pulses   = e.fired;
    return e;
  endfunction

  function automatic pat_t fill(input logic [3:0] v);
    pat_t p;
    for (int k = 0; k < 16; k++) p[k] = v;
    return p;
  endfunction

  // Monitor: count out pulses per window, score each done pulse.
  always @(negedge clk) begin
    exp_t  e;
    int    qs;
    logic  o, d, f;
    logic [3:0] t;
    string nm;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        pulses[i]  = 0;
        first_k[i] = -1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        o  = (i == 0) ? out8 : out4;
        d  = (i == 0) ? done8 : done4;
        f  = (i == 0) ? fired8 : fired4;
        t  = (i == 0) ? ot8 : ot4;
        nm = (i == 0) ? "acc8" : "acc4";
        if (o) begin
          if (pulses[i] == 0) first_k[i] = cyc_cnt - win_start - 1;
          pulses[i]++;
        end
        if (d) begin
          qs = (i == 0) ? q8.size() : q4.size();
          check_eq({nm, "_done_expected"}, (qs > 0) ? 1 : 0, 1);
          if (qs > 0) begin
            e = (i == 0) ? q8.pop_front() : q4.pop_front();
            check_eq({nm, "_out_time"}, int'(t), e.out_time);
            check_eq({nm, "_fired"}, int'(f), e.fired);
            check_eq({nm, "_pulses"}, pulses[i], e.pulses);
            if (e.fired != 0) check_eq({nm, "_out_cycle"}, first_k[i], e.k);
          end
          pulses[i]  = 0;
          first_k[i] = -1;
        end
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_out8"}, int'(out8), 0);
    check_eq({tag, "_done8"}, int'(done8), 0);
    check_eq({tag, "_fired8"}, int'(fired8), 0);
    check_eq({tag, "_ot8"}, int'(ot8), 0);
    check_eq({tag, "_out4"}, int'(out4), 0);
    check_eq({tag, "_done4"}, int'(done4), 0);
    check_eq({tag, "_fired4"}, int'(fired4), 0);
    check_eq({tag, "_ot4"}, int'(ot4), 0);
  endtask

  // abort_at >= 0 pulls reset during that window cycle instead of completing.
  task automatic run_window(input int thr, input pat_t pat, input int abort_at = -1);
    @(negedge clk);
    threshold = thr[7:0];
    in_rdy    = 1'b1;
    prod_in   = 4'($urandom);
    win_start = cyc_cnt + 1;
    if (abort_at < 0) begin
      q8.push_back(model(thr, pat, 8));
      q4.push_back(model(thr & 15, pat, 4));
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        reset_n = 1'b0;
        in_rdy  = 1'b0;
        @(negedge clk);
        check_idle_zero("abort");
        reset_n = 1'b1;
        return;
      end
      in_rdy    = 1'($urandom_range(0, 1));
      threshold = 8'($urandom);
      prod_in   = pat[k];
    end
    @(negedge clk);
    in_rdy  = 1'b1;
    prod_in = 4'($urandom);
    @(negedge clk);
    in_rdy  = 1'b0;
  endtask

  initial begin
    pat_t p;
    repeat (2) begin
      @(negedge clk);
      prod_in = 4'($urandom);
      in_rdy  = 1'($urandom_range(0, 1));
    end
    check_idle_zero("reset");
    reset_n = 1'b1;
    in_rdy  = 1'b0;

    p = fill(4'b0000);
    p[0] = 4'b0111;
    run_window(3, p);
    run_window(5, fill(4'b0001));
    run_window(2, fill(4'b0000));
    for (int k = 0; k < 16; k++) p[k] = 4'($urandom);
    run_window(0, p);
    run_window(16, fill(4'b0001));
    run_window(200, fill(4'b1111));
    run_window(15, fill(4'b1111));
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 16; k++) p[k] = 4'($urandom) & 4'($urandom);
      run_window($urandom_range(0, 30), p);
    end
    run_window(15, fill(4'b1111), 6);
    run_window(7, fill(4'b0011));

    repeat (4) @(negedge clk);
    check_eq("sb8_drained", q8.size(), 0);
    check_eq("sb4_drained", q4.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
